// File: rtl/edge_event_capture.sv
// Multi-channel edge capture: synchronise, glitch-filter, then derive mode-gated edge pulses,
// sticky pending flags, an aggregated interrupt and a saturating event counter.
module edge_event_capture #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   a_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   clear_i,
  input  logic                cnt_clr_i,
  output logic [NUM_CH-1:0]   level_o,
  output logic [NUM_CH-1:0]   rising_edge_o,
  output logic [NUM_CH-1:0]   falling_edge_o,
  output logic [NUM_CH-1:0]   pending_o,
  output logic                irq_o,
  output logic [CNT_W-1:0]    event_cnt_o
);

  localparam int unsigned FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned SW = CNT_W + $clog2(2 * NUM_CH) + 1;
  localparam logic [SW-1:0] CntMax = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] sync_last;
  logic [NUM_CH-1:0] lvl_q, lvl_d;
  logic [FW-1:0]     fcnt_q [NUM_CH];
  logic [FW-1:0]     fcnt_d [NUM_CH];
  logic [NUM_CH-1:0] rise_en, fall_en;
  logic [NUM_CH-1:0] rise_q, rise_d, fall_q, fall_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     n_evt, cnt_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= a_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // A new value is accepted only after it has differed from lvl for FILTER_CYCLES cycles.
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < NUM_CH; i++) begin
      fcnt_d[i]  = '0;
      rise_en[i] = mode_i[2*i];
      fall_en[i] = mode_i[2*i+1];
      if (sync_last[i] != lvl_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_CYCLES - 1)) begin
          lvl_d[i] = sync_last[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rise_d = lvl_d & ~lvl_q & rise_en;
    fall_d = ~lvl_d & lvl_q & fall_en;
    // Set wins over a simultaneous clear.
    pend_d = (pend_q & ~clear_i) | rise_d | fall_d;
    n_evt  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_evt = n_evt + SW'(rise_d[i]) + SW'(fall_d[i]);
    end
    cnt_sum = (cnt_clr_i ? '0 : {{(SW - CNT_W){1'b0}}, cnt_q}) + n_evt;
    cnt_d   = (cnt_sum > CntMax) ? CntMax[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= '0;
    end else begin
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NUM_CH; i++) fcnt_q[i] <= fcnt_d[i];
    end
  end

  assign level_o        = lvl_q;
  assign rising_edge_o  = rise_q;
  assign falling_edge_o = fall_q;
  assign pending_o      = pend_q;
  assign irq_o          = |pend_q;
  assign event_cnt_o    = cnt_q;

endmodule
